// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq
// Purpose  : Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU with a
//            fixed latency of XLEN+1 cycles from start to done.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_en,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] multiplicand_i,
  input  logic [XLEN-1:0] multiplier_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  localparam int            CW     = $clog2(XLEN);
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_op;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  logic              w_rs1_neg;
  logic              w_rs2_neg;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [2*XLEN-1:0] w_product;

  // Sign handling is applied to magnitudes up front so CALC is purely unsigned.
  assign w_rs1_neg = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && multiplicand_i[XLEN-1];
  assign w_rs2_neg = (op_i == OP_MULH) && multiplier_i[XLEN-1];
  assign w_mag1    = w_rs1_neg ? (~multiplicand_i + 1'b1) : multiplicand_i;
  assign w_mag2    = w_rs2_neg ? (~multiplier_i + 1'b1) : multiplier_i;
  assign w_product = r_neg ? (~r_acc + 1'b1) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (mul_en) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == C_LAST) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state == ST_CALC) || (r_state == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mul_en) begin
            r_op     <= op_i;
            r_mcand  <= {{XLEN{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= w_rs1_neg ^ w_rs2_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_CALC: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          r_cnt    <= r_cnt + CW'(1);
        end
        ST_FIN: begin
          r_result <= (r_op == OP_MUL) ? w_product[XLEN-1:0] : w_product[2*XLEN-1:XLEN];
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign done_o   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq
// Purpose  : Self-checking bench for mul_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        mul_en;
  logic [1:0]  op_i;
  logic [31:0] multiplicand_i;
  logic [31:0] multiplier_i;
  logic [31:0] result_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;

  mul_seq #(.XLEN(32)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mul_en         (mul_en),
    .op_i           (op_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .result_o       (result_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: extend operands per op signedness, take the 64-bit product.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Presents a request, lets one edge take it, then scrambles the inputs.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    mul_en         = 1'b1;
    op_i           = op;
    multiplicand_i = a;
    multiplier_i   = b;
    @(posedge clk);
    #1;
    mul_en         = 1'b0;
    op_i           = 2'($urandom);
    multiplicand_i = $urandom;
    multiplier_i   = $urandom;
  endtask

  // Counts edges from the start edge until done_o, bounded.
  task automatic wait_done(input int base, output int lat, output int busy_cnt);
    lat      = base;
    busy_cnt = 0;
    while (lat < 80) begin
      if (busy_o) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
      if (done_o) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int lat;
    int bc;
    logic [31:0] exp;
    exp = ref_mul(op, a, b);
    start_op(op, a, b);
    wait_done(0, lat, bc);
    chk({tag, "_lat"}, 32'(lat), 32'd33);
    chk({tag, "_res"}, result_o, exp);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'b0, done_o}, 32'd0);
  endtask

  logic [1:0]  d_op [9]  = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11};
  logic [31:0] d_a  [9]  = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] d_b  [9]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
  logic [31:0] d_exp [9] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h0, 32'hFFFF_FFFE,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

  initial begin
    int lat;
    int bc;
    int pulses;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;

    rst_n          = 1'b0;
    mul_en         = 1'b0;
    op_i           = 2'b00;
    multiplicand_i = '0;
    multiplier_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result_o, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First directed case also checks how long busy stays high.
    start_op(d_op[0], d_a[0], d_b[0]);
    wait_done(0, lat, bc);
    chk("mul_neg3_lat", 32'(lat), 32'd33);
    chk("mul_neg3_busy", 32'(bc), 32'd33);
    chk("mul_neg3_res", result_o, d_exp[0]);
    chk("mul_neg3_model", ref_mul(d_op[0], d_a[0], d_b[0]), d_exp[0]);
    @(posedge clk);
    #1;

    for (int i = 1; i < 9; i++) begin
      start_op(d_op[i], d_a[i], d_b[i]);
      wait_done(0, lat, bc);
      chk($sformatf("dir%0d_lat", i), 32'(lat), 32'd33);
      chk($sformatf("dir%0d_res", i), result_o, d_exp[i]);
      @(posedge clk);
      #1;
    end

    // A second request 5 cycles into CALC must be dropped.
    start_op(2'b01, 32'hFFFF_FFFE, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    mul_en         = 1'b1;
    op_i           = 2'b00;
    multiplicand_i = 32'd9;
    multiplier_i   = 32'd9;
    @(posedge clk);
    #1;
    mul_en = 1'b0;
    wait_done(5, lat, bc);
    chk("ign_lat", 32'(lat), 32'd33);
    chk("ign_res", result_o, 32'hFFFF_FFFF);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) pulses++;
    end
    chk("ign_extra_done", 32'(pulses), 32'd0);
    chk("ign_busy_idle", {31'b0, busy_o}, 32'd0);

    // Back-to-back: next request presented during the done cycle.
    start_op(2'b00, 32'd2, 32'd2);
    wait_done(0, lat, bc);
    chk("b2b1_lat", 32'(lat), 32'd33);
    chk("b2b1_res", result_o, 32'd4);
    start_op(2'b11, 32'd3, 32'd5);
    wait_done(0, lat, bc);
    chk("b2b2_lat", 32'(lat), 32'd33);
    chk("b2b2_res", result_o, 32'd0);
    @(posedge clk);
    #1;

    // Reset 10 cycles into CALC aborts the operation silently.
    start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_result", result_o, 32'h0);
    chk("abort_busy", {31'b0, busy_o}, 32'd0);
    chk("abort_done", {31'b0, done_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    do_op("post_rst", 2'b00, 32'd6, 32'd7);
    chk("post_rst_42", result_o, 32'd42);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h8000_0000;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'd1;
        default: b = $urandom;
      endcase
      do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential radix-2 shift-add multiplier covering the RISC-V M-extension multiply ops MUL, MULH, MULHSU and MULHU.
- It is the forward-direction counterpart of the core's iterative divider and shares its start/finish handshake style.
- It sits beside the divider in the EX stage and returns one XLEN-bit result per accepted request at a fixed latency.

Parameters:
XLEN, 32, operand and result width in bits (must be >= 4).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mul_en  input  1  start request; sampled only while in IDLE
op_i  input  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
multiplicand_i  input  XLEN  rs1 operand
multiplier_i  input  XLEN  rs2 operand
result_o  output  XLEN  registered result; holds its value until the next done_o
busy_o  output  1  high in CALC and FIN
done_o  output  1  single-cycle pulse when result_o is updated

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state returns to IDLE.
  - result_o=0, done_o=0, busy_o=0.
  - Internal accumulator, counter and operand registers are cleared.
  - Any operation in progress is discarded.
- States: IDLE, CALC, FIN.
- IDLE:
  - On a clock edge with mul_en=1, latch op_i.
  - Latch magnitude registers:
    - |rs1| if rs1 is treated as signed (MULH, MULHSU) and its MSB is 1; otherwise raw rs1.
    - |rs2| if rs2 is treated as signed (MULH only) and its MSB is 1; otherwise raw rs2.
  - Latch neg = sign_rs1_effective XOR sign_rs2_effective.
  - Clear the 2*XLEN-bit accumulator and the counter, then go to CALC.
  - Magnitudes are held as unsigned XLEN-bit values, so |0x8000_0000| = 2^31 is exact.
  - MUL uses unsigned magnitudes, since the low half is sign-independent.
- CALC:
  - Each cycle, if the multiplier LSB is 1, add the zero-extended multiplicand into the accumulator.
  - Then shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
  - After exactly XLEN iterations, go to FIN.
  - There is no early termination.
- FIN:
  - product = neg ? two's-complement negation of the accumulator (2*XLEN bits) : accumulator.
  - result_o = op==MUL ? product[XLEN-1:0] : product[2*XLEN-1:XLEN].
  - done_o=1 for this cycle only; next state is IDLE.
- Latency:
  - mul_en is sampled at edge k.
  - result_o and done_o are updated at edge k+XLEN+1, i.e. done_o is high during the cycle after that edge.
  - For XLEN=32, that is 33 edges after the start.
- Handshake rules:
  - mul_en while busy_o=1 is ignored; there is no queueing.
  - Operands and op_i are captured only at the start edge. Changes to them during CALC have no effect.
  - Back-to-back operation is allowed: mul_en asserted in the cycle where done_o=1 (state already IDLE) starts a new operation at that edge.
- Boundary cases:
  - A zero operand gives result 0 for every op, with no negative-zero artefacts: negating 0 yields 0.
  - rst_n deasserting mid-cycle has no effect until the next edge.
  - rst_n asserted during CALC or FIN: no done_o pulse is emitted for the aborted operation.

Test Plan:
- MUL, rs1=7, rs2=0xFFFF_FFFD (-3) -> done_o after 33 edges; result_o=0xFFFF_FFEB; busy_o high for the 33 cycles between start and done.
- MULH 0x8000_0000 × 0x8000_0000 -> 0x4000_0000; MUL with the same operands -> 0x0000_0000.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU 0xFFFF_FFFF (-1) × 0xFFFF_FFFF (unsigned) -> 0xFFFF_FFFF; MULH -2 × 3 -> 0xFFFF_FFFF; MULH -1 × -1 -> 0x0000_0000.
- Zero and busy handling:
  - MUL 0 × 0x8000_0000 -> 0.
  - mul_en pulsed again, with different operands, 5 cycles into CALC -> ignored; the first result is unchanged and only one done_o pulse occurs.
- Back-to-back: second mul_en asserted in the done_o cycle (MULHU 3×5 after MUL 2×2) -> first result_o=4, then second result_o=0 exactly 33 edges later; no extra cycles between the operations.
- Reset during operation: rst_n pulled low 10 cycles into CALC -> result_o=0, busy_o=0, done_o=0 immediately, with no later done_o. A fresh MUL 6×7 afterwards -> 42.
